// File: rtl/regfile_param.sv
// Parametrised multi-port register file with a post-reset scrub FSM and optional zero register.
// Define REGFILE_BYPASS_EN to forward a same-cycle write to matching read ports (write-first).
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 3,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     write_enable,
  input  logic [ADDR_W-1:0]        w_addr,
  input  logic [DATA_W-1:0]        w_data,
  input  logic [NUM_RD-1:0]        rd_enable,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic                     init_busy,
  output logic                     wr_dropped
);

  localparam int                DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   scnt, scnt_next;
  logic                drop_next;
  logic                wr_zero;
  logic                wr_commit;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem [DEPTH];

  assign wr_zero = (ZERO_REG != 0) && (w_addr == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= INIT;
      scnt       <= '0;
      wr_dropped <= 1'b0;
    end else begin
      state      <= state_next;
      scnt       <= scnt_next;
      wr_dropped <= drop_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_next = state;
    scnt_next  = scnt;
    drop_next  = 1'b0;
    wr_commit  = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = w_addr;
    mem_wdata  = w_data;
    init_busy  = (state == INIT);
    unique case (state)
      INIT: begin
        mem_we    = 1'b1;
        mem_waddr = scnt;
        mem_wdata = '0;
        scnt_next = scnt + ADDR_W'(1);
        drop_next = write_enable;
        if (scnt == LAST) state_next = RUN;
      end
      RUN: begin
        wr_commit = write_enable && !wr_zero;
        mem_we    = wr_commit;
      end
    endcase
  end

  // NOTE: the array has no reset term; the scrub FSM clears it one entry per cycle instead.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[mem_waddr] <= mem_wdata;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rv;
    logic              mask;

    assign ra   = rd_addr[k*ADDR_W +: ADDR_W];
    assign mask = reset || init_busy || !rd_enable[k] || ((ZERO_REG != 0) && (ra == '0));

    always_comb begin
      rv = mem[ra];
`ifdef REGFILE_BYPASS_EN
      if (wr_commit && (w_addr == ra)) rv = w_data;
`endif
    end

    assign rd_data[k*DATA_W +: DATA_W] = mask ? '0 : rv;
  end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised multi-port integer register file for the core's ID/WB stages, replacing the fixed 32x32, three-read-port file. Provides one synchronous write port from WB, NUM_RD combinational read ports to ID (the third and later ports serve MAC-style three-operand instructions), an optional hardwired zero register, and a same-cycle write-to-read bypass. After reset it clears the array with a sequential scrub state machine, one entry per cycle, instead of a single-cycle bulk reset.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 3, number of read ports (1..4)
- ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes; 0 = entry 0 is an ordinary register

- clk  in  1  core clock, rising-edge
- reset  in  1  asynchronous, active-high reset
- write_enable  in  1  WB write strobe
- w_addr  in  ADDR_W  WB write address
- w_data  in  DATA_W  WB write data
- rd_enable  in  NUM_RD  per-port read enable; bit k controls port k
- rd_addr  in  NUM_RD*ADDR_W  port k address at bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  port k data at bits [k*DATA_W +: DATA_W]
- init_busy  out  1  high while the scrub FSM is clearing the array
- wr_dropped  out  1  registered pulse: a write was discarded during the scrub

## Operation
- FSM states: INIT (scrub) and RUN. While reset is asserted, the FSM is forced to INIT, scrub counter scnt = 0, wr_dropped = 0, init_busy = 1.
- INIT: each rising edge with reset low writes 0 to entry scnt and increments scnt. On the edge where scnt = DEPTH-1, the FSM moves to RUN; scnt wraps to 0 and is unused in RUN.
- INIT: every write_enable is discarded. On the next edge, wr_dropped = 1 for one cycle; otherwise it is 0.
- RUN: on a rising edge with write_enable = 1, entry[w_addr] <= w_data. The write is skipped when ZERO_REG = 1 and w_addr = 0.
- Reads are combinational per port. rd_data[k] = 0 if any of the following holds: reset = 1, init_busy = 1, rd_enable[k] = 0, or (ZERO_REG = 1 and rd_addr[k] = 0).
- Otherwise rd_data[k] = bypass value if a bypass hit applies (see Configuration), else entry[rd_addr[k]].
- Multiple ports may read the same address in the same cycle; all return the same value.
- Array contents are undefined from reset assertion until scrub completion and are never observable, because reads return 0 during that window.

## Timing
- Reset values: rd_data = 0 on all ports, init_busy = 1, wr_dropped = 0. These hold asynchronously while reset = 1.
- Scrub latency: init_busy stays high for exactly DEPTH rising edges after reset deasserts and falls after the DEPTH-th edge. DEPTH = 32 gives 32 cycles.
- Write latency: one edge. Data written at edge N is visible in the array-read path from edge N onward.
- Read latency: zero cycles (combinational from rd_addr/rd_enable).
- Reset asserted mid-scrub or mid-RUN: the FSM returns to INIT and scnt restarts at 0. A full DEPTH-cycle scrub follows the next deassertion.
- A write arriving on the same edge as the INIT-to-RUN transition is dropped and flagged in wr_dropped.

## Configuration
- REGFILE_BYPASS_EN defined: in RUN, if write_enable = 1, w_addr = rd_addr[k], and the write is not to a suppressed zero register, then rd_data[k] = w_data in that same cycle (write-first). This removes the WB-to-ID hazard.
- REGFILE_BYPASS_EN undefined: no bypass. rd_data[k] shows the old entry value until the edge commits the write, so the pipeline must stall or forward externally.

## Test plan
- Reset release, DEPTH=32: init_busy stays 1 for 32 edges and then goes 0. A read of every address returns 0. A write of 0x55 at cycle 5 of the scrub produces wr_dropped = 1 for one cycle, and a later read of that address returns 0.
- RUN write/read: write 0xDEADBEEF to addr 7, then read addr 7 on ports 0, 1 and 2 simultaneously → all return 0xDEADBEEF. With rd_enable = 3'b101, port 1 returns 0.
- Zero register with ZERO_REG=1: write 0x1234 to addr 0 → reading addr 0 returns 0. Repeat with ZERO_REG=0 → reading addr 0 returns 0x1234.
- Bypass: addr 3 holds 0x11, and the same cycle drives write_enable with w_addr = 3, w_data = 0x22 and rd_addr[0] = 3. With REGFILE_BYPASS_EN, rd_data[0] = 0x22 before the edge; without it, rd_data[0] = 0x11 before the edge and 0x22 after.
- Reset mid-operation: assert reset asynchronously at scrub count 17 → rd_data = 0 and init_busy = 1 immediately. After release, init_busy stays high for a full 32 edges.
- Parameter sweep: DATA_W=64, ADDR_W=4, NUM_RD=4 → scrub lasts 16 cycles. Write 0xFFFF_FFFF_0000_0001 to addr 15 → the value reads back on all four ports.
